// File: rtl/sca_mux_arb.sv
// Round-robin arbiter that shares one two-input mux between requesters A and B
// and feeds a single valid/ready output register. Optional macro: SCA_MUX_ARB_LOCK_EN.

module sca_mux #(
  parameter int SIZE = 1
) (
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            SEL,
  output logic [SIZE-1:0] OUT
);

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_bit
    assign OUT[gi] = SEL ? B[gi] : A[gi];
  end

endmodule

module sca_mux_arb #(
  parameter int SIZE = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [SIZE-1:0] A,
  input  logic            REQ_A,
  output logic            ACK_A,
  input  logic [SIZE-1:0] B,
  input  logic            REQ_B,
  output logic            ACK_B,
  output logic [SIZE-1:0] OUT,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic            OUT_SRC,
  output logic [7:0]      XFER_CNT
`ifdef SCA_MUX_ARB_LOCK_EN
  ,
  input  logic            LOCK_A,
  input  logic            LOCK_B
`endif
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]      state_reg;
  logic [0:0]      state_next;
  logic [SIZE-1:0] out_reg;
  logic            src_reg;
  logic            last_reg;
  logic [7:0]      cnt_reg;

  logic            winner;
  logic            cap;
  logic [SIZE-1:0] mux_out;

  // Default is a tie: grant the requester that was not served last.
  always_comb begin
    winner = ~last_reg;
    if (REQ_A && !REQ_B) begin
      winner = 1'b0;
    end else if (!REQ_A && REQ_B) begin
      winner = 1'b1;
`ifdef SCA_MUX_ARB_LOCK_EN
    end else if (last_reg ? LOCK_B : LOCK_A) begin
      winner = last_reg;
`endif
    end
  end

  // Reset gates capture so no ACK can escape while RST is high.
  assign cap = (REQ_A | REQ_B) & ((state_reg == ST_EMPTY) | OUT_READY) & ~RST;

  assign ACK_A = cap & ~winner;
  assign ACK_B = cap & winner;

  sca_mux #(
    .SIZE(SIZE)
  ) u_mux (
    .A  (A),
    .B  (B),
    .SEL(winner),
    .OUT(mux_out)
  );

  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_EMPTY) begin
      if (cap) state_next = ST_FULL;
    end else begin
      if (OUT_READY && !cap) state_next = ST_EMPTY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_EMPTY;
      out_reg   <= '0;
      src_reg   <= 1'b0;
      last_reg  <= 1'b1;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      if (cap) begin
        out_reg  <= mux_out;
        src_reg  <= winner;
        last_reg <= winner;
        cnt_reg  <= cnt_reg + 8'd1;
      end
    end
  end

  assign OUT       = out_reg;
  assign OUT_VALID = (state_reg == ST_FULL);
  assign OUT_SRC   = src_reg;
  assign XFER_CNT  = cnt_reg;

endmodule

// File: tb/tb_sca_mux_arb.sv
// Directed bench for sca_mux_arb (SIZE=6) with a cycle-level reference model.

module tb_sca_mux_arb;

  logic       clk;
  logic       RST;
  logic [5:0] A;
  logic       REQ_A;
  logic       ACK_A;
  logic [5:0] B;
  logic       REQ_B;
  logic       ACK_B;
  logic [5:0] OUT;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic       OUT_SRC;
  logic [7:0] XFER_CNT;
  logic       LOCK_A;
  logic       LOCK_B;

  int n_cmp = 0;
  int n_bad = 0;

  sca_mux_arb #(
    .SIZE(6)
  ) dut (
    .CLK      (clk),
    .RST      (RST),
    .A        (A),
    .REQ_A    (REQ_A),
    .ACK_A    (ACK_A),
    .B        (B),
    .REQ_B    (REQ_B),
    .ACK_B    (ACK_B),
    .OUT      (OUT),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_SRC  (OUT_SRC),
    .XFER_CNT (XFER_CNT)
`ifdef SCA_MUX_ARB_LOCK_EN
    ,
    .LOCK_A   (LOCK_A),
    .LOCK_B   (LOCK_B)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: one output slot, the id of the last source served,
  // and an unbounded capture count reduced modulo 256 when compared.
  bit         model_init = 1'b0;
  bit         m_valid;
  logic [5:0] m_word;
  bit         m_src;
  bit         m_served;
  int         m_count;

  initial begin
    bit take;
    bit win;
    forever begin
      @(negedge clk);
      if (model_init) begin
        chk("m_valid", OUT_VALID, m_valid);
        chk("m_count", XFER_CNT, m_count % 256);
        if (m_valid) begin
          chk("m_word", OUT, m_word);
          chk("m_src", OUT_SRC, m_src);
        end
      end
      if (RST) begin
        chk("m_ack_a_rst", ACK_A, 0);
        chk("m_ack_b_rst", ACK_B, 0);
        m_valid    = 1'b0;
        m_word     = '0;
        m_src      = 1'b0;
        m_served   = 1'b1;
        m_count    = 0;
        model_init = 1'b1;
      end else if (model_init) begin
        take = (REQ_A || REQ_B) && (!m_valid || OUT_READY);
        if (REQ_A && REQ_B) begin
          win = !m_served;
`ifdef SCA_MUX_ARB_LOCK_EN
          if (m_served == 1'b0 && LOCK_A) win = 1'b0;
          if (m_served == 1'b1 && LOCK_B) win = 1'b1;
`endif
        end else begin
          win = REQ_B;
        end
        chk("m_ack_a", ACK_A, take && !win);
        chk("m_ack_b", ACK_B, take && win);
        if (take) begin
          m_word   = win ? B : A;
          m_src    = win;
          m_served = win;
          m_valid  = 1'b1;
          m_count++;
        end else if (OUT_READY) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] iv;
    RST = 1'b1; REQ_A = 1'b1; REQ_B = 1'b1;
    A = 6'b100100; B = 6'b110011; OUT_READY = 1'b1;
    LOCK_A = 1'b0; LOCK_B = 1'b0;

    // Reset held two cycles with both requests up.
    look();
    chk("rst_ack_a", ACK_A, 0);
    chk("rst_ack_b", ACK_B, 0);
    step(); look();
    chk("rst_out", OUT, 6'b000000);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_cnt", XFER_CNT, 0);
    chk("rst_ack_a2", ACK_A, 0);

    // Tie and alternation.
    step(); RST = 1'b0; look();
    chk("tie1_ack_a", ACK_A, 1);
    chk("tie1_ack_b", ACK_B, 0);
    chk("tie1_valid", OUT_VALID, 0);
    step(); look();
    chk("tie2_ack_b", ACK_B, 1);
    chk("tie2_out", OUT, 6'b100100);
    chk("tie2_src", OUT_SRC, 0);
    chk("tie2_cnt", XFER_CNT, 1);
    step(); look();
    chk("tie3_ack_a", ACK_A, 1);
    chk("tie3_out", OUT, 6'b110011);
    chk("tie3_src", OUT_SRC, 1);
    chk("tie3_cnt", XFER_CNT, 2);

    // Backpressure: the A word is held for five cycles.
    step(); OUT_READY = 1'b0; look();
    chk("bp_out", OUT, 6'b100100);
    chk("bp_src", OUT_SRC, 0);
    chk("bp_cnt", XFER_CNT, 3);
    chk("bp_noack", {ACK_A, ACK_B}, 0);
    repeat (4) begin
      step(); look();
      chk("bp_hold_out", OUT, 6'b100100);
      chk("bp_hold_valid", OUT_VALID, 1);
      chk("bp_hold_noack", {ACK_A, ACK_B}, 0);
    end
    step(); OUT_READY = 1'b1; look();
    chk("bp_rel_ack_b", ACK_B, 1);
    chk("bp_rel_ack_a", ACK_A, 0);
    step(); REQ_A = 1'b0; REQ_B = 1'b0; look();
    chk("bp_rel_out", OUT, 6'b110011);
    chk("bp_rel_src", OUT_SRC, 1);
    chk("bp_rel_cnt", XFER_CNT, 4);
    step(); look();
    chk("drain_valid", OUT_VALID, 0);

    // Single requester B.
    step(); RST = 1'b1;
    step(); RST = 1'b0; REQ_B = 1'b1; B = 6'b101001; look();
    chk("sb1_ack_b", ACK_B, 1);
    chk("sb1_ack_a", ACK_A, 0);
    step(); look();
    chk("sb2_ack_b", ACK_B, 1);
    chk("sb2_out", OUT, 6'b101001);
    chk("sb2_src", OUT_SRC, 1);
    chk("sb2_cnt", XFER_CNT, 1);
    step(); look();
    chk("sb3_ack_b", ACK_B, 1);
    chk("sb3_cnt", XFER_CNT, 2);
    step(); REQ_B = 1'b0; look();
    chk("sb4_cnt", XFER_CNT, 3);
    chk("sb4_valid", OUT_VALID, 1);
    chk("sb4_noack", ACK_B, 0);
    step(); look();
    chk("sb5_valid", OUT_VALID, 0);

    // 256 captures wrap the counter, then reset while a word is held.
    step(); RST = 1'b1;
    for (int i = 0; i < 256; i++) begin
      step();
      iv = i;
      RST = 1'b0; REQ_A = 1'b1; REQ_B = iv[2];
      A = iv[5:0]; B = ~iv[5:0]; OUT_READY = 1'b1;
    end
    step(); REQ_A = 1'b0; REQ_B = 1'b0; OUT_READY = 1'b0; look();
    chk("wrap_cnt", XFER_CNT, 0);
    chk("wrap_valid", OUT_VALID, 1);
    step(); RST = 1'b1; REQ_A = 1'b1; REQ_B = 1'b1; OUT_READY = 1'b1; look();
    chk("mrst_ack", {ACK_A, ACK_B}, 0);
    chk("mrst_valid_pre", OUT_VALID, 1);
    step(); RST = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0; OUT_READY = 1'b0; look();
    chk("mrst_valid", OUT_VALID, 0);
    chk("mrst_out", OUT, 6'b000000);
    chk("mrst_cnt", XFER_CNT, 0);
    step(); look();
    chk("mrst_valid2", OUT_VALID, 0);

`ifdef SCA_MUX_ARB_LOCK_EN
    // Lock keeps A on the mux for a burst; round-robin resumes after.
    step(); RST = 1'b1;
    step(); RST = 1'b0; REQ_A = 1'b1; REQ_B = 1'b1; LOCK_A = 1'b1;
    A = 6'b100100; B = 6'b110011; OUT_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      look();
      chk("lock_ack_a", ACK_A, 1);
      chk("lock_ack_b", ACK_B, 0);
      step();
    end
    LOCK_A = 1'b0;
    look();
    chk("unlock_ack_b", ACK_B, 1);
    chk("unlock_ack_a", ACK_A, 0);
    step(); REQ_A = 1'b0; REQ_B = 1'b0;
`endif

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
